// File: rtl/input_debouncer_x4.sv
// Four-channel input conditioner for the priority encoder: two-FF synchroniser,
// per-channel stability counter, registered clean levels and 0->1 rise pulses.
module input_debouncer_x4 #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] raw,
   output logic [3:0] x,
   output logic [3:0] x_rise,
   output logic       busy
);

   // Count value at which a persistent difference is finally accepted.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [3:0]       r_s1;
   logic [3:0]       r_s2;
   logic [3:0]       r_x;
   logic [3:0]       r_rise;
   logic [CNT_W-1:0] r_cnt [4];
   logic             w_busy;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1   <= '0;
         r_s2   <= '0;
         r_x    <= '0;
         r_rise <= '0;
         for (int unsigned i = 0; i < 4; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_s1 <= raw;
         r_s2 <= r_s1;
         for (int unsigned i = 0; i < 4; i++) begin
            r_rise[i] <= 1'b0;
            // Any edge where the synced level agrees with x cancels the count.
            if (r_s2[i] == r_x[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == LAST_CNT) begin
               r_x[i]    <= r_s2[i];
               r_rise[i] <= r_s2[i];
               r_cnt[i]  <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CNT_ONE;
            end
         end
      end
   end

   always_comb begin
      w_busy = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         w_busy = w_busy | (r_cnt[i] != '0);
      end
   end

   assign x      = r_x;
   assign x_rise = r_rise;
   assign busy   = w_busy;

endmodule

// File: tb/tb_input_debouncer_x4.sv
// Directed bench for input_debouncer_x4: stimulus pushes hand-computed expected
// outputs into a scoreboard; a monitor pops one entry per cycle and compares.
module tb_input_debouncer_x4;

   typedef struct {
      string      name;
      logic [3:0] ex;
      logic [3:0] er;
      logic       eb;
   } exp_t;

   logic       clk;
   logic       reset;
   logic [3:0] raw;
   logic [3:0] x;
   logic [3:0] x_rise;
   logic       busy;

   exp_t sb[$];
   int   n_pass;
   int   n_total;

   input_debouncer_x4 #(
      .DEBOUNCE_CYCLES(4),
      .CNT_W          (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .raw   (raw),
      .x     (x),
      .x_rise(x_rise),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Waits for the next edge, queues the outputs expected after that edge,
   // then drives the inputs that the following edge will sample.
   task automatic cyc(input string nm, input logic rst, input logic [3:0] r,
                      input logic [3:0] ex, input logic [3:0] er, input logic eb);
      exp_t e;
      @(posedge clk);
      e.name = nm;
      e.ex   = ex;
      e.er   = er;
      e.eb   = eb;
      sb.push_back(e);
      #1;
      reset = rst;
      raw   = r;
   endtask

   task automatic hold(input int n, input string nm, input logic rst, input logic [3:0] r,
                       input logic [3:0] ex, input logic [3:0] er, input logic eb);
      for (int k = 0; k < n; k++) cyc(nm, rst, r, ex, er, eb);
   endtask

   // Full level change with no bounce: 2 sync edges, 3 counting edges, update on 6th.
   task automatic settle(input string nm, input logic [3:0] from_x, input logic [3:0] to_raw,
                         input logic [3:0] rise);
      cyc (nm,    1'b0, to_raw, from_x, 4'b0000, 1'b0);
      hold(2, nm, 1'b0, to_raw, from_x, 4'b0000, 1'b0);
      hold(3, nm, 1'b0, to_raw, from_x, 4'b0000, 1'b1);
      cyc (nm,    1'b0, to_raw, to_raw, rise,    1'b0);
      cyc (nm,    1'b0, to_raw, to_raw, 4'b0000, 1'b0);
   endtask

   // Monitor: every cycle is an output presentation for this block.
   initial begin
      exp_t e;
      n_pass  = 0;
      n_total = 0;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_total++;
            if (x === e.ex && x_rise === e.er && busy === e.eb) begin
               n_pass++;
            end else begin
               $display("FAIL %s: got x=%b x_rise=%b busy=%b, expected x=%b x_rise=%b busy=%b",
                        e.name, x, x_rise, busy, e.ex, e.er, e.eb);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      raw   = 4'b1111;

      // 1: two reset edges with raw high
      cyc("rst_edge1", 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0);
      cyc("rst_edge2", 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      hold(2, "idle", 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0);

      // 2: single channel rise
      settle("ch0_rise", 4'b0000, 4'b0001, 4'b0001);

      // 3: 3-cycle pulse on raw[1] is rejected
      cyc ("glitch_sync",   1'b0, 4'b0011, 4'b0001, 4'b0000, 1'b0);
      hold(2, "glitch_sync", 1'b0, 4'b0011, 4'b0001, 4'b0000, 1'b0);
      cyc ("glitch_cnt",    1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b1);
      hold(2, "glitch_cnt",  1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b1);
      hold(2, "glitch_done", 1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0);

      // release ch0, then 4: all channels rise together and fall together
      settle("ch0_fall", 4'b0001, 4'b0000, 4'b0000);
      settle("all_rise", 4'b0000, 4'b1111, 4'b1111);
      settle("all_fall", 4'b1111, 4'b0000, 4'b0000);

      // 5: reset at cnt==2 discards the count and forces a full resync
      cyc ("mid_sync",     1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0);
      hold(2, "mid_sync",  1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0);
      cyc ("mid_cnt1",     1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1);
      cyc ("mid_cnt2",     1'b1, 4'b0100, 4'b0000, 4'b0000, 1'b1);
      cyc ("mid_reset",    1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0);
      hold(2, "re_sync",   1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0);
      hold(3, "re_cnt",    1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1);
      cyc ("re_rise",      1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b0);
      cyc ("re_hold",      1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b0);

      // 6: bounce on raw[3]: 1,0,1,1,0,1,1,1,1
      cyc("bnc_e0",  1'b0, 4'b1100, 4'b0100, 4'b0000, 1'b0);
      cyc("bnc_e1",  1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b0);
      cyc("bnc_e2",  1'b0, 4'b1100, 4'b0100, 4'b0000, 1'b0);
      cyc("bnc_e3",  1'b0, 4'b1100, 4'b0100, 4'b0000, 1'b1);
      cyc("bnc_e4",  1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b0);
      cyc("bnc_e5",  1'b0, 4'b1100, 4'b0100, 4'b0000, 1'b1);
      cyc("bnc_e6",  1'b0, 4'b1100, 4'b0100, 4'b0000, 1'b1);
      cyc("bnc_e7",  1'b0, 4'b1100, 4'b0100, 4'b0000, 1'b0);
      cyc("bnc_e8",  1'b0, 4'b1100, 4'b0100, 4'b0000, 1'b1);
      cyc("bnc_e9",  1'b0, 4'b1100, 4'b0100, 4'b0000, 1'b1);
      cyc("bnc_e10", 1'b0, 4'b1100, 4'b0100, 4'b0000, 1'b1);
      cyc("bnc_e11", 1'b0, 4'b1100, 4'b1100, 4'b1000, 1'b0);
      hold(3, "bnc_hold", 1'b0, 4'b1100, 4'b1100, 4'b0000, 1'b0);

      // drain the scoreboard with a bounded wait
      for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
      #1;
      if (sb.size() > 0) begin
         n_total++;
         $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
